// File: rtl/jtk054000_pkg.sv
// -----------------------------------------------------------------------------
// jtk054000_pkg
// Shared definitions for the jtk054000 collision-check sequencer:
//   - AW_DEF  : default coordinate width
//   - LIM_W   : width of the summed extent/tolerance limit (8+8+8 bits -> 10)
//   - state_t : sequencer states
//   - lim_sum : extent + extent + tolerance, zero-extended to LIM_W
// -----------------------------------------------------------------------------
package jtk054000_pkg;

   localparam int AW_DEF = 24;
   localparam int LIM_W  = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_XDIF,
      S_XCMP,
      S_YDIF,
      S_YCMP,
      S_DONE
   } state_t;

   // Largest possible sum is 3*255 = 765, which fits in LIM_W bits.
   function automatic logic [LIM_W-1:0] lim_sum(input logic [7:0] ext0,
                                                input logic [7:0] ext1,
                                                input logic [7:0] tol);
      return LIM_W'(ext0) + LIM_W'(ext1) + LIM_W'(tol);
   endfunction

endpackage

// File: rtl/jtk054000_if.sv
// -----------------------------------------------------------------------------
// jtk054000_if
// Request/result bundle of the collision-check sequencer.
//   start                 : one-cycle check request
//   o0x/o0y/o1x/o1y [AW]  : object positions, unsigned
//   o0w/o0h/o1w/o1h [8]   : object half-extents, unsigned
//   dx/dy           [8]   : extra tolerance, unsigned
//   busy, done, hit       : status / one-cycle result pulse / last result
//   dout            [8]   : CPU read value {7'b0, ~hit}
//   hit_cnt         [8]   : debug hit counter
// Modports: master (requester side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface jtk054000_if
   import jtk054000_pkg::*;
#(
   parameter int AW = AW_DEF
);

   logic          start;
   logic [AW-1:0] o0x, o0y, o1x, o1y;
   logic [7:0]    o0w, o0h, o1w, o1h;
   logic [7:0]    dx, dy;
   logic          busy;
   logic          done;
   logic          hit;
   logic [7:0]    dout;
   logic [7:0]    hit_cnt;

   modport master (
      output start, o0x, o0y, o1x, o1y, o0w, o0h, o1w, o1h, dx, dy,
      input  busy, done, hit, dout, hit_cnt
   );

   modport slave (
      input  start, o0x, o0y, o1x, o1y, o0w, o0h, o1w, o1h, dx, dy,
      output busy, done, hit, dout, hit_cnt
   );

endinterface

// File: rtl/jtk054000_absdiff.sv
// -----------------------------------------------------------------------------
// jtk054000_absdiff
// Absolute difference |b - a| of two unsigned AW-bit values, evaluated in
// AW+1 bits so a large separation never wraps into a small distance.
//   a_i, b_i   [AW]   : operands
//   absdiff_o  [AW+1] : |b_i - a_i|
// -----------------------------------------------------------------------------
module jtk054000_absdiff #(
   parameter int AW = 24
) (
   input  logic [AW-1:0] a_i,
   input  logic [AW-1:0] b_i,
   output logic [AW:0]   absdiff_o
);

   logic [AW:0] diff;

   always_comb begin
      diff      = {1'b0, b_i} - {1'b0, a_i};
      // The extra top bit is the borrow: set means b < a, so take a - b.
      absdiff_o = diff[AW] ? ({1'b0, a_i} - {1'b0, b_i}) : diff;
   end

endmodule

// File: rtl/jtk054000_seq.sv
// -----------------------------------------------------------------------------
// jtk054000_seq
// Sequential box-overlap checker. On start the inputs are snapshotted; the X
// axis and then the Y axis are each evaluated through one shared absolute-
// difference unit (diff step, then compare step), and the ANDed result is
// published 5 clocks after the start was sampled. A start arriving while busy
// is remembered in a single pending flag and re-runs the check from DONE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : jtk054000_if.slave (request inputs, status/result outputs)
// Build option: define JTK054000_HITCNT_EN to enable the saturating hit
// counter on bus.hit_cnt; otherwise hit_cnt is tied to zero.
// -----------------------------------------------------------------------------
module jtk054000_seq
   import jtk054000_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   jtk054000_if.slave   bus
);

   state_t           state_q;
   logic [AW-1:0]    s0x_q, s0y_q, s1x_q, s1y_q;
   logic [7:0]       s0w_q, s0h_q, s1w_q, s1h_q, sdx_q, sdy_q;
   logic [AW:0]      diff_q;
   logic [LIM_W-1:0] lim_q;
   logic             hx_q, hy_q;
   logic             pending_q;
   logic             busy_q, done_q, hit_q;

   logic [AW-1:0]    op_a, op_b;
   logic [AW:0]      absdiff;
   logic [LIM_W-1:0] lim_d;
   logic             take_snap;
   logic             hit_d;
   logic             in_range;

   // Operand selection for the single shared difference unit: only XDIF and
   // YDIF register its output, so X operands are the idle default.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      op_a  = s0x_q;
      op_b  = s1x_q;
      lim_d = lim_sum(s0w_q, s1w_q, sdx_q);
      if (state_q == S_YDIF) begin
         op_a  = s0y_q;
         op_b  = s1y_q;
         lim_d = lim_sum(s0h_q, s1h_q, sdy_q);
      end
      // A start seen in the DONE cycle merges into the pending request.
      take_snap = ((state_q == S_IDLE) && bus.start) ||
                  ((state_q == S_DONE) && (pending_q || bus.start));
      hit_d     = hx_q & hy_q;
      in_range  = (diff_q <= (AW+1)'(lim_q));
   end

   jtk054000_absdiff #(.AW(AW)) u_absdiff (
      .a_i       (op_a),
      .b_i       (op_b),
      .absdiff_o (absdiff)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         s0x_q     <= '0;
         s0y_q     <= '0;
         s1x_q     <= '0;
         s1y_q     <= '0;
         s0w_q     <= '0;
         s0h_q     <= '0;
         s1w_q     <= '0;
         s1h_q     <= '0;
         sdx_q     <= '0;
         sdy_q     <= '0;
         diff_q    <= '0;
         lim_q     <= '0;
         hx_q      <= 1'b0;
         hy_q      <= 1'b0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
         done_q <= 1'b0;

         if (take_snap) begin
            s0x_q <= bus.o0x;
            s0y_q <= bus.o0y;
            s1x_q <= bus.o1x;
            s1y_q <= bus.o1y;
            s0w_q <= bus.o0w;
            s0h_q <= bus.o0h;
            s1w_q <= bus.o1w;
            s1h_q <= bus.o1h;
            sdx_q <= bus.dx;
            sdy_q <= bus.dy;
         end

         if (busy_q && bus.start && (state_q != S_DONE)) begin
            pending_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_XDIF;
                  busy_q  <= 1'b1;
               end
            end
            S_XDIF: begin
               diff_q  <= absdiff;
               lim_q   <= lim_d;
               state_q <= S_XCMP;
            end
            S_XCMP: begin
               hx_q    <= in_range;
               state_q <= S_YDIF;
            end
            S_YDIF: begin
               diff_q  <= absdiff;
               lim_q   <= lim_d;
               state_q <= S_YCMP;
            end
            S_YCMP: begin
               hy_q    <= in_range;
               state_q <= S_DONE;
            end
            S_DONE: begin
               hit_q     <= hit_d;
               done_q    <= 1'b1;
               pending_q <= 1'b0;
               if (pending_q || bus.start) begin
                  state_q <= S_XDIF;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef JTK054000_HITCNT_EN
   logic [7:0] hit_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q <= '0;
      end else if ((state_q == S_DONE) && hit_d && (hit_cnt_q != 8'hFF)) begin
         hit_cnt_q <= hit_cnt_q + 8'd1;
      end
   end

   assign bus.hit_cnt = hit_cnt_q;
`else
   assign bus.hit_cnt = 8'h00;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hit  = hit_q;
   assign bus.dout = {7'b0, ~hit_q};

endmodule

// File: doc/jtk054000_seq.md
JTK054000_SEQ -- requirements
Module: jtk054000_seq

Interface
REQ-001 SHALL have parameter AW, default 24, the coordinate width of o0x/o0y/o1x/o1y.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  one-cycle request to run a collision check (driven by the MMR write strobe).
REQ-005 SHALL have ports: o0x, o0y, o1x, o1y  in  AW  object 0/1 position, unsigned.
REQ-006 SHALL have ports: o0w, o0h, o1w, o1h  in  8  object 0/1 half-extents, unsigned.
REQ-007 SHALL have ports: dx, dy  in  8  extra X/Y tolerance, unsigned.
REQ-008 SHALL have port: busy  out  1  high while a check is in progress.
REQ-009 SHALL have port: done  out  1  one-cycle pulse when a result is published.
REQ-010 SHALL have port: hit  out  1  last published result, 1 = objects overlap.
REQ-011 SHALL have port: dout  out  8  CPU read value {7'b0, ~hit}.
REQ-012 SHALL have port: hit_cnt  out  8  debug hit counter (see Configuration).

Function
REQ-013 SHALL implement states IDLE, XDIF, XCMP, YDIF, YCMP, DONE.
REQ-014 IDLE + start at an edge: snapshot all position, extent and tolerance inputs; go to XDIF; busy high from the next cycle.
REQ-015 Each of XDIF -> XCMP -> YDIF -> YCMP -> DONE SHALL advance unconditionally, one clock per state.
REQ-016 XDIF SHALL register adx = |o1x - o0x|, computed in AW+1 bits with no modular wrap.
REQ-017 XDIF SHALL also register limx = o0w + o1w + dx, zero-extended to 10 bits.
REQ-018 XCMP SHALL latch hx = (adx <= limx).
REQ-019 YDIF and YCMP SHALL compute the Y-axis terms the same way and latch hy.
REQ-020 DONE SHALL update hit = hx & hy and pulse done for that cycle.
REQ-021 Latency: hit/done SHALL change exactly 5 edges after the edge that sampled start.
REQ-022 Only the snapshot SHALL feed the arithmetic; input changes while busy SHALL NOT affect the running check.
REQ-023 start while busy (including the DONE cycle) SHALL set a single pending flag; further starts while the flag is set SHALL merge into it.
REQ-024 At DONE with pending set: clear pending, take a new snapshot, go to XDIF, keep busy high. done still pulses for the completed check.
REQ-025 At DONE without pending: go to IDLE; busy low in IDLE.
REQ-026 A single shared absolute-difference unit SHALL serve both axes; X and Y SHALL NOT be computed in parallel.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, busy 0, done 0, hit 0, dout 8'h01, pending 0, snapshots 0, hit_cnt 0.
REQ-028 Reset mid-check SHALL abandon the check and publish no result.

Configuration
REQ-029 With JTK054000_HITCNT_EN defined, hit_cnt SHALL increment by one at each DONE with hit = 1, saturating at 8'hFF.
REQ-030 Without JTK054000_HITCNT_EN, hit_cnt SHALL be constant 0 and the counter logic SHALL be omitted.

Structure
REQ-031 Package jtk054000_pkg SHALL hold the state enum, the limit width constant (10) and the default AW.
REQ-032 Sub-module jtk054000_absdiff SHALL hold the shared (AW+1)-bit subtract-and-absolute unit.

Verification
REQ-033 Overlap: o0x=0x000100, o1x=0x000110, o0w=o1w=8, dx=0; Y identical -> hit=1, dout=8'h00, done exactly 5 edges after start.
REQ-034 Boundary: adx=limx=0x20 -> hit=1; adx=0x21, limx=0x20 -> hit=0, dout=8'h01.
REQ-035 Wide separation: o0x=0xFFFFF0, o1x=0x000010, extents 0xFF, dx=0xFF -> hit=0 (no wrap).
REQ-036 Retrigger: start at cycle 0, again at cycles 2 and 3 -> two done pulses, 5 edges apart; busy continuously high; second result uses inputs present at the first DONE.
REQ-037 Reset: assert rst_n at cycle 3 of a check -> busy=0, done never pulses, hit=0, hit_cnt=0.
REQ-038 Counter: with JTK054000_HITCNT_EN, 300 hitting checks -> hit_cnt=8'hFF; without the macro, hit_cnt stays 0.
